// File: rtl/scan_loader.sv
// Scan-chain loader: fetches bitstream words and shifts them MSB-first into a
// downstream configuration scan chain. Define SCAN_LOADER_CRC_EN to add a CRC-16/CCITT-FALSE.
module scan_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              scan_en,
  output logic              scan_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORD_W_C    = WCNT_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WORD_W-1:0]  shreg;
  logic [CNT_W-1:0]   bits_left;
  logic [WCNT_W-1:0]  word_left;
  logic [WCNT_W-1:0]  word_load;
  logic               accept;

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    data_ready = 1'b0;
    scan_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        data_ready = 1'b1;
        if (data_valid) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        scan_en = 1'b1;
        if (bits_left == CNT_W'(1)) begin
          next_state = DONE;
        end else if (word_left == WCNT_W'(1)) begin
          next_state = FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign accept  = data_valid & data_ready;
  assign scan_in = scan_en & shreg[WORD_W-1];

  // The final word of a load may be only partially used; its low bits are dropped.
  always_comb begin
    if (32'(bits_left) < 32'(WORD_W)) begin
      word_load = WCNT_W'(bits_left);
    end else begin
      word_load = WORD_W_C;
    end
  end

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      shreg     <= '0;
      bits_left <= '0;
      word_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bits_left <= CHAIN_LEN_C;
          end
        end
        FETCH: begin
          if (accept) begin
            shreg     <= data_in;
            word_left <= word_load;
          end
        end
        SHIFT: begin
          shreg     <= shreg << 1;
          bits_left <= bits_left - CNT_W'(1);
          word_left <= word_left - WCNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SCAN_LOADER_CRC_EN
  logic [15:0] crc_q;
  logic        crc_fb;

  assign crc_fb = crc_q[15] ^ scan_in;

  // Restart on every new load so the value covers exactly one load's bits.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      crc_q <= 16'hFFFF;
    end else if (state == IDLE && start) begin
      crc_q <= 16'hFFFF;
    end else if (state == SHIFT) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Scoreboard bench for scan_loader: three instances (16/12/72-bit chains), expected
// scan bits queued when words are driven and popped as the DUT shifts them out.
module tb_scan_loader;

  logic        scan_clk = 1'b0;
  logic        rst;
  logic        start      [3];
  logic        data_valid [3];
  logic [7:0]  data_in    [3];
  logic        data_ready [3];
  logic        scan_en    [3];
  logic        scan_in    [3];
  logic        busy       [3];
  logic        done       [3];
  logic [15:0] crc        [3];

  int          checks = 0;
  int          errors = 0;
  int          scan_cnt  [3] = '{0, 0, 0};
  int          done_cnt  [3] = '{0, 0, 0};
  int          ready_cnt [3] = '{0, 0, 0};
  logic [71:0] chain     [3] = '{72'd0, 72'd0, 72'd0};
  bit          exp_q [$];

  always #5 scan_clk = ~scan_clk;

  scan_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .scan_clk(scan_clk), .rst(rst), .start(start[0]), .data_in(data_in[0]),
    .data_valid(data_valid[0]), .data_ready(data_ready[0]), .scan_en(scan_en[0]),
    .scan_in(scan_in[0]), .busy(busy[0]), .done(done[0]), .crc(crc[0])
  );

  scan_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .scan_clk(scan_clk), .rst(rst), .start(start[1]), .data_in(data_in[1]),
    .data_valid(data_valid[1]), .data_ready(data_ready[1]), .scan_en(scan_en[1]),
    .scan_in(scan_in[1]), .busy(busy[1]), .done(done[1]), .crc(crc[1])
  );

  scan_loader #(.CHAIN_LEN(72), .WORD_W(8)) dut72 (
    .scan_clk(scan_clk), .rst(rst), .start(start[2]), .data_in(data_in[2]),
    .data_valid(data_valid[2]), .data_ready(data_ready[2]), .scan_en(scan_en[2]),
    .scan_in(scan_in[2]), .busy(busy[2]), .done(done[2]), .crc(crc[2])
  );

  task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] crcExpect(input logic [15:0] model);
`ifdef SCAN_LOADER_CRC_EN
    return model;
`else
    return 16'h0000 & model;
`endif
  endfunction

  // Downstream chain model plus scoreboard pop, sampled away from the active edge.
  always @(negedge scan_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (scan_en[i]) begin
        scan_cnt[i]++;
        chain[i] = {chain[i][70:0], scan_in[i]};
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("extra_bit_dut%0d", i), 72'(1), 72'(0));
        end else begin
          checkOutput($sformatf("scan_in_dut%0d", i), 72'(scan_in[i]), 72'(exp_q.pop_front()));
        end
      end else begin
        checkOutput($sformatf("scan_in_idle_dut%0d", i), 72'(scan_in[i]), 72'(0));
      end
      if (done[i]) done_cnt[i]++;
      if (data_ready[i]) ready_cnt[i]++;
    end
  end

  task automatic applyStimulus(input int id, input int chain_len, input logic [7:0] words [9],
                               input int nwords, input int gap, input bit start_in_shift,
                               input logic [71:0] exp_chain, input string name);
    int          pushed = 0;
    int          base_scan, base_done, base_ready, k;
    bit          ok;
    logic [15:0] crc_m = 16'hFFFF;
    logic [71:0] mask;
    mask = (72'(1) << chain_len) - 72'(1);
    @(posedge scan_clk); #1;
    base_scan  = scan_cnt[id];
    base_done  = done_cnt[id];
    base_ready = ready_cnt[id];
    start[id] = 1'b1;
    @(posedge scan_clk); #1;
    start[id] = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      for (int b = 7; b >= 0; b--) begin
        if (pushed < chain_len) begin
          exp_q.push_back(words[w][b]);
          crc_m = crcStep(crc_m, words[w][b]);
          pushed++;
        end
      end
      if (w > 0 && gap > 0) begin
        data_valid[id] = 1'b0;
        k = 0; ok = 0;
        while (!ok && k < 100) begin
          @(negedge scan_clk);
          ok = data_ready[id];
          k++;
        end
        if (!ok) checkOutput({name, "_fetch_timeout"}, 72'(0), 72'(1));
        repeat (gap) @(posedge scan_clk);
        #1;
      end
      data_in[id]    = words[w];
      data_valid[id] = 1'b1;
      k = 0; ok = 0;
      while (!ok && k < 100) begin
        @(negedge scan_clk);
        ok = data_ready[id];
        @(posedge scan_clk); #1;
        k++;
      end
      if (!ok) checkOutput({name, "_accept_timeout"}, 72'(0), 72'(1));
      if (start_in_shift && w == 0) begin
        start[id] = 1'b1;
        @(posedge scan_clk); #1;
        start[id] = 1'b0;
      end
    end
    data_valid[id] = 1'b0;
    k = 0; ok = 0;
    while (!ok && k < 300) begin
      @(negedge scan_clk);
      ok = done[id];
      k++;
    end
    if (!ok) checkOutput({name, "_done_timeout"}, 72'(0), 72'(1));
    checkOutput({name, "_crc_at_done"}, 72'(crc[id]), 72'(crcExpect(crc_m)));
    @(negedge scan_clk); #1;
    checkOutput({name, "_busy_after_done"}, 72'(busy[id]), 72'(0));
    checkOutput({name, "_scan_cycles"}, 72'(scan_cnt[id] - base_scan), 72'(chain_len));
    checkOutput({name, "_done_pulses"}, 72'(done_cnt[id] - base_done), 72'(1));
    checkOutput({name, "_fetch_cycles"}, 72'(ready_cnt[id] - base_ready), 72'(nwords + gap));
    checkOutput({name, "_chain"}, chain[id] & mask, exp_chain);
    checkOutput({name, "_queue_left"}, 72'(exp_q.size()), 72'(0));
    repeat (3) @(negedge scan_clk);
    #1;
    checkOutput({name, "_still_idle"}, 72'(busy[id]), 72'(0));
    checkOutput({name, "_done_once"}, 72'(done_cnt[id] - base_done), 72'(1));
    checkOutput({name, "_crc_stable"}, 72'(crc[id]), 72'(crcExpect(crc_m)));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [7:0] words [9];
    logic [15:0] rst_crc;
    int base_scan, base_done, k;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; data_valid[i] = 1'b0; data_in[i] = 8'h00;
    end
    for (int i = 0; i < 9; i++) words[i] = 8'h00;
`ifdef SCAN_LOADER_CRC_EN
    rst_crc = 16'hFFFF;
`else
    rst_crc = 16'h0000;
`endif
    rst = 1'b1;
    repeat (3) @(posedge scan_clk);
    @(negedge scan_clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_scan_en_%0d", i), 72'(scan_en[i]), 72'(0));
      checkOutput($sformatf("rst_ready_%0d", i), 72'(data_ready[i]), 72'(0));
      checkOutput($sformatf("rst_busy_%0d", i), 72'(busy[i]), 72'(0));
      checkOutput($sformatf("rst_done_%0d", i), 72'(done[i]), 72'(0));
      checkOutput($sformatf("rst_crc_%0d", i), 72'(crc[i]), 72'(rst_crc));
    end
    rst = 1'b0;

    $display("[TB] basic 16-bit load");
    words[0] = 8'hA5; words[1] = 8'h3C;
    applyStimulus(0, 16, words, 2, 0, 1'b0, 72'hA53C, "load16");

    $display("[TB] 12-bit chain with partial last word");
    words[0] = 8'hAB; words[1] = 8'hCD;
    applyStimulus(1, 12, words, 2, 0, 1'b0, 72'hABC, "load12");

    $display("[TB] 16-bit load with delayed second word");
    words[0] = 8'hA5; words[1] = 8'h3C;
    applyStimulus(0, 16, words, 2, 5, 1'b0, 72'hA53C, "gap16");

    $display("[TB] start pulsed during shift, then a fresh load");
    applyStimulus(0, 16, words, 2, 0, 1'b1, 72'hA53C, "startshift");
    words[0] = 8'h5A; words[1] = 8'hC3;
    applyStimulus(0, 16, words, 2, 0, 1'b0, 72'h5AC3, "reload16");

    $display("[TB] reset after five shifted bits");
    @(posedge scan_clk); #1;
    base_scan = scan_cnt[0];
    base_done = done_cnt[0];
    start[0] = 1'b1;
    @(posedge scan_clk); #1;
    start[0] = 1'b0;
    data_in[0] = 8'hA5;
    data_valid[0] = 1'b1;
    for (int b = 7; b >= 0; b--) exp_q.push_back(data_in[0][b]);
    k = 0; ok = 0;
    while (!ok && k < 100) begin
      @(negedge scan_clk); #1;
      if (scan_cnt[0] - base_scan >= 1) data_valid[0] = 1'b0;
      ok = (scan_cnt[0] - base_scan == 5);
      k++;
    end
    if (!ok) checkOutput("rst_mid_timeout", 72'(0), 72'(1));
    rst = 1'b1;
    @(posedge scan_clk);
    @(negedge scan_clk); #1;
    checkOutput("rst_mid_scan_en", 72'(scan_en[0]), 72'(0));
    checkOutput("rst_mid_busy", 72'(busy[0]), 72'(0));
    checkOutput("rst_mid_no_done", 72'(done_cnt[0] - base_done), 72'(0));
    checkOutput("rst_mid_bits", 72'(scan_cnt[0] - base_scan), 72'(5));
    checkOutput("rst_mid_chain", chain[0] & 72'h1F, 72'h14);
    rst = 1'b0;
    exp_q.delete();
    words[0] = 8'hA5; words[1] = 8'h3C;
    applyStimulus(0, 16, words, 2, 0, 1'b0, 72'hA53C, "after_rst16");

    $display("[TB] 72-bit chain, ASCII 123456789");
    for (int i = 0; i < 9; i++) words[i] = 8'h31 + 8'(i);
    applyStimulus(2, 72, words, 9, 0, 1'b0, 72'h313233343536373839, "load72");
`ifdef SCAN_LOADER_CRC_EN
    checkOutput("crc_check_string", 72'(crc[2]), 72'(16'h29B1));
`else
    checkOutput("crc_check_string", 72'(crc[2]), 72'(16'h0000));
`endif

    repeat (2) @(posedge scan_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 16, SHALL set the total number of configuration bits in the downstream scan chain (>= 1).
REQ-002 Parameter WORD_W, default 8, SHALL set the width of each bitstream word accepted on data_in (>= 1).
REQ-003 scan_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request a full chain load; sampled only in IDLE.
REQ-006 data_in  input  WORD_W  SHALL carry the bitstream word, MSB shifted first.
REQ-007 data_valid  input  1  SHALL indicate data_in holds a valid word.
REQ-008 data_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-009 scan_en  output  1  SHALL drive the chain's shift enable.
REQ-010 scan_in  output  1  SHALL drive the serial bit into the chain's head.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 done  output  1  SHALL pulse high one cycle when a load completes.
REQ-013 crc  output  16  SHALL present the CRC of shifted bits (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, FETCH, SHIFT, DONE.
REQ-015 IDLE: start=1 SHALL move to FETCH next cycle, clear bit counter to CHAIN_LEN bits remaining; start while not IDLE SHALL be ignored.
REQ-016 FETCH: data_ready SHALL be 1; word accepted when data_valid & data_ready; on accept SHALL load data_in into shift register and move to SHIFT next cycle; data_ready SHALL be 0 in all other states.
REQ-017 SHIFT: scan_en SHALL be 1 and scan_in SHALL equal shift register MSB each cycle; shift register shifts left by 1, remaining-bit count decrements by 1 per cycle.
REQ-018 Words per load SHALL be ceil(CHAIN_LEN/WORD_W); last word SHALL shift only its upper CHAIN_LEN-(words-1)*WORD_W bits, lower bits discarded.
REQ-019 After last bit of a non-final word SHALL return to FETCH; after last chain bit SHALL enter DONE.
REQ-020 scan_en SHALL be 1 for exactly CHAIN_LEN cycles per load, never in IDLE, FETCH or DONE; data_valid gaps SHALL only stall (scan_en low), never drop or duplicate bits.
REQ-021 DONE: done=1 for one cycle, then IDLE; start in DONE ignored.
REQ-022 scan_in SHALL be 0 whenever scan_en is 0.
REQ-023 After done, chain content SHALL equal the bitstream's first CHAIN_LEN bits, first bit at chain MSB.

Reset
REQ-024 rst=1 SHALL force next cycle: IDLE, scan_en=0, scan_in=0, data_ready=0, busy=0, done=0, crc=16'hFFFF, counters and shift register 0.
REQ-025 rst mid-load SHALL abort without done; chain keeps partial contents; next start SHALL restart a full CHAIN_LEN load.

Configuration
REQ-026 Macro SCAN_LOADER_CRC_EN defined: crc SHALL be CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final xor) over every bit driven while scan_en=1, reinitialised to 0xFFFF on leaving IDLE, stable from done until next start.
REQ-027 Macro undefined: crc SHALL be constant 16'h0000 and no CRC logic SHALL be synthesised; all other behaviour identical.

Verification
REQ-028 CHAIN_LEN=16, WORD_W=8, start, words 0xA5 then 0x3C, valid always high -> 16 scan_en cycles, scan_in sequence 1010010100111100, one done pulse, chain holds 0xA53C.
REQ-029 CHAIN_LEN=12, words 0xAB, 0xCD -> exactly 12 scan_en cycles, chain holds 0xABC, bits 0xD discarded.
REQ-030 CHAIN_LEN=16, second word delayed 5 cycles after FETCH entry -> scan_en low 5 cycles, total still 16, chain 0xA53C.
REQ-031 start pulsed during SHIFT -> ignored; only one done; next start after done begins a new load.
REQ-032 rst after 5 shift bits -> next cycle scan_en=0, busy=0, no done; new start reloads all 16 bits.
REQ-033 CRC_EN, CHAIN_LEN=72, WORD_W=8, words ASCII "123456789" (0x31..0x39) -> crc=0x29B1 at done; without macro crc=0x0000.
